// File: rtl/r5p_wbu.sv
// Write-back unit: merges ALU results with in-order load responses into the single GPR write port,
// tracking outstanding loads in a small descriptor FIFO and flagging RAW hazards for decode.
module r5p_wbu #(
  parameter int unsigned AW    = 5,
  parameter int unsigned XW    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_vld,
  output logic          alu_rdy,
  input  logic [AW-1:0] alu_rd,
  input  logic [XW-1:0] alu_dat,
  input  logic          ld_vld,
  output logic          ld_rdy,
  input  logic [AW-1:0] ld_rd,
  input  logic [2:0]    ld_f3,
  input  logic [1:0]    ld_off,
  input  logic          bus_rvl,
  input  logic [XW-1:0] bus_rdt,
  input  logic          bus_err,
  input  logic [AW-1:0] a_rs1,
  input  logic [AW-1:0] a_rs2,
  output logic          hzd,
  output logic          busy,
  output logic          ld_err,
  output logic          e_rd,
  output logic [AW-1:0] a_rd,
  output logic [XW-1:0] d_rd
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [2:0]    f3;
    logic [1:0]    off;
  } desc_t;

  desc_t            fifo_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic             e_rd_q, e_rd_d, ld_err_q, ld_err_d;
  logic [AW-1:0]    a_rd_q, a_rd_d;
  logic [XW-1:0]    d_rd_q, d_rd_d;

  logic  full, empty, push, pop, alu_acc;
  desc_t head;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [XW-1:0] ld_dat;

  // Circular buffer with per-slot valid bits: the slot under wptr is occupied only when full,
  // the slot under rptr is free only when empty.
  assign full    = vld_q[wptr_q];
  assign empty   = ~vld_q[rptr_q];
  assign ld_rdy  = ~full;
  assign busy    = ~empty;
  assign push    = ld_vld & ~full;
  assign pop     = bus_rvl & ~empty;
  assign alu_rdy = ~bus_rvl;
  assign alu_acc = alu_vld & ~bus_rvl;
  assign head    = fifo_q[rptr_q];

  assign ld_byte = bus_rdt[{head.off, 3'b000} +: 8];
  assign ld_half = bus_rdt[{head.off[1], 4'b0000} +: 16];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ld_dat = bus_rdt;
    case (head.f3)
      3'b000:  ld_dat = {{(XW-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_dat = {{(XW-16){ld_half[15]}}, ld_half};
      3'b100:  ld_dat = {{(XW-8){1'b0}}, ld_byte};
      3'b101:  ld_dat = {{(XW-16){1'b0}}, ld_half};
      default: ld_dat = bus_rdt;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wptr_q] = 1'b1;
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
  end

  // Load responses win the port; writes to x0 are consumed but never raise e_rd.
  always_comb begin
    e_rd_d   = 1'b0;
    a_rd_d   = a_rd_q;
    d_rd_d   = d_rd_q;
    ld_err_d = 1'b0;
    if (pop) begin
      if (bus_err) begin
        ld_err_d = 1'b1;
      end else if (head.rd != '0) begin
        e_rd_d = 1'b1;
        a_rd_d = head.rd;
        d_rd_d = ld_dat;
      end
    end else if (alu_acc && alu_rd != '0) begin
      e_rd_d = 1'b1;
      a_rd_d = alu_rd;
      d_rd_d = alu_dat;
    end
  end

  always_comb begin
    hzd = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && fifo_q[i].rd != '0 &&
          (fifo_q[i].rd == a_rs1 || fifo_q[i].rd == a_rs2)) begin
        hzd = 1'b1;
      end
    end
    // The GPR only holds the value after the e_rd cycle, so the in-flight write still blocks.
    if (e_rd_q && (a_rd_q == a_rs1 || a_rd_q == a_rs2)) begin
      hzd = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      vld_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      e_rd_q   <= 1'b0;
      a_rd_q   <= '0;
      d_rd_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      e_rd_q   <= e_rd_d;
      a_rd_q   <= a_rd_d;
      d_rd_q   <= d_rd_d;
      ld_err_q <= ld_err_d;
    end
  end

  // NOTE: descriptor payload is left unreset; the valid bits alone decide whether a slot means anything.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr_q] <= '{rd: ld_rd, f3: ld_f3, off: ld_off};
    end
  end

  assign e_rd   = e_rd_q;
  assign a_rd   = a_rd_q;
  assign d_rd   = d_rd_q;
  assign ld_err = ld_err_q;

endmodule

// File: tb/tb_r5p_wbu.sv
// Directed bench for r5p_wbu: inputs change 1ns after the rising edge, outputs are checked
// in the same half-cycle, expected values are hand-computed.
module tb_r5p_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_vld = 1'b0;
  logic        alu_rdy;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_dat = '0;
  logic        ld_vld = 1'b0;
  logic        ld_rdy;
  logic [4:0]  ld_rd = '0;
  logic [2:0]  ld_f3 = '0;
  logic [1:0]  ld_off = '0;
  logic        bus_rvl = 1'b0;
  logic [31:0] bus_rdt = '0;
  logic        bus_err = 1'b0;
  logic [4:0]  a_rs1 = '0;
  logic [4:0]  a_rs2 = '0;
  logic        hzd, busy, ld_err, e_rd;
  logic [4:0]  a_rd;
  logic [31:0] d_rd;

  int n_chk = 0;
  int n_err = 0;

  r5p_wbu #(.AW(5), .XW(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_rd(alu_rd), .alu_dat(alu_dat),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_rd(ld_rd), .ld_f3(ld_f3), .ld_off(ld_off),
    .bus_rvl(bus_rvl), .bus_rdt(bus_rdt), .bus_err(bus_err),
    .a_rs1(a_rs1), .a_rs2(a_rs2), .hzd(hzd), .busy(busy), .ld_err(ld_err),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_e_rd", 32'(e_rd), 32'd0);
    check("rst_a_rd", 32'(a_rd), 32'd0);
    check("rst_d_rd", d_rd, 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hzd", 32'(hzd), 32'd0);
    check("rst_ld_rdy", 32'(ld_rdy), 32'd1);
    rst = 1'b1;
    tick();

    // ALU write with idle bus
    alu_vld = 1'b1; alu_rd = 5'd5; alu_dat = 32'h0000_1234;
    settle();
    check("alu_rdy_idle", 32'(alu_rdy), 32'd1);
    tick();
    alu_vld = 1'b0; a_rs1 = 5'd5;
    settle();
    check("alu_e_rd", 32'(e_rd), 32'd1);
    check("alu_a_rd", 32'(a_rd), 32'd5);
    check("alu_d_rd", d_rd, 32'h0000_1234);
    check("hzd_inflight_x5", 32'(hzd), 32'd1);
    tick();
    check("alu_e_rd_drop", 32'(e_rd), 32'd0);
    check("hzd_x5_clear", 32'(hzd), 32'd0);
    check("hold_d_rd", d_rd, 32'h0000_1234);
    a_rs1 = 5'd0;

    // Two loads fill the FIFO; a third request is refused
    ld_vld = 1'b1; ld_rd = 5'd6; ld_f3 = 3'b000; ld_off = 2'd3;
    tick();
    ld_rd = 5'd7; ld_f3 = 3'b101; ld_off = 2'd2;
    tick();
    ld_rd = 5'd8; ld_f3 = 3'b010; ld_off = 2'd0; a_rs1 = 5'd7; a_rs2 = 5'd6;
    settle();
    check("full_ld_rdy", 32'(ld_rdy), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    check("hzd_pending_x7_x6", 32'(hzd), 32'd1);
    tick();
    ld_vld = 1'b0; a_rs2 = 5'd0;

    // Collision: load response and ALU in the same cycle
    bus_rvl = 1'b1; bus_rdt = 32'h80FF_0000;
    alu_vld = 1'b1; alu_rd = 5'd10; alu_dat = 32'h0000_AAAA;
    settle();
    check("coll_alu_rdy", 32'(alu_rdy), 32'd0);
    tick();
    bus_rvl = 1'b0;
    settle();
    check("lb_e_rd", 32'(e_rd), 32'd1);
    check("lb_a_rd", 32'(a_rd), 32'd6);
    check("lb_d_rd", d_rd, 32'hFFFF_FF80);
    check("after_pop_ld_rdy", 32'(ld_rdy), 32'd1);
    check("alu_rdy_retry", 32'(alu_rdy), 32'd1);
    check("hzd_x7_still", 32'(hzd), 32'd1);
    tick();
    alu_vld = 1'b0;
    bus_rvl = 1'b1; bus_rdt = 32'h80FF_0000;
    settle();
    check("alu_late_a_rd", 32'(a_rd), 32'd10);
    check("alu_late_d_rd", d_rd, 32'h0000_AAAA);
    tick();
    bus_rvl = 1'b0;
    settle();
    check("lhu_e_rd", 32'(e_rd), 32'd1);
    check("lhu_a_rd", 32'(a_rd), 32'd7);
    check("lhu_d_rd", d_rd, 32'h0000_80FF);
    check("hzd_x7_writing", 32'(hzd), 32'd1);
    check("refused_push_busy", 32'(busy), 32'd0);
    tick();
    check("hzd_x7_clear", 32'(hzd), 32'd0);
    check("idle_e_rd", 32'(e_rd), 32'd0);

    // Bus error on load to x9
    ld_vld = 1'b1; ld_rd = 5'd9; ld_f3 = 3'b010; ld_off = 2'd0; a_rs1 = 5'd9;
    tick();
    ld_vld = 1'b0;
    settle();
    check("hzd_pending_x9", 32'(hzd), 32'd1);
    bus_rvl = 1'b1; bus_err = 1'b1; bus_rdt = 32'h1111_2222;
    tick();
    bus_rvl = 1'b0; bus_err = 1'b0;
    settle();
    check("err_e_rd", 32'(e_rd), 32'd0);
    check("err_ld_err", 32'(ld_err), 32'd1);
    check("err_hzd_clear", 32'(hzd), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    check("err_d_rd_hold", d_rd, 32'h0000_80FF);
    tick();
    check("ld_err_pulse_end", 32'(ld_err), 32'd0);
    a_rs1 = 5'd0;

    // Push and pop in the same cycle; LH uses off[1], LW ignores off
    ld_vld = 1'b1; ld_rd = 5'd11; ld_f3 = 3'b001; ld_off = 2'd2;
    tick();
    ld_rd = 5'd12; ld_f3 = 3'b010; ld_off = 2'd1;
    bus_rvl = 1'b1; bus_rdt = 32'h8001_1234;
    tick();
    ld_vld = 1'b0;
    bus_rdt = 32'hDEAD_BEEF;
    settle();
    check("lh_a_rd", 32'(a_rd), 32'd11);
    check("lh_d_rd", d_rd, 32'hFFFF_8001);
    check("pushpop_busy", 32'(busy), 32'd1);
    tick();
    bus_rvl = 1'b0;
    settle();
    check("lw_a_rd", 32'(a_rd), 32'd12);
    check("lw_d_rd", d_rd, 32'hDEAD_BEEF);

    // x0 destinations: load and ALU consumed without a write
    ld_vld = 1'b1; ld_rd = 5'd0; ld_f3 = 3'b010; ld_off = 2'd0;
    tick();
    ld_vld = 1'b0;
    settle();
    check("hzd_x0_entry", 32'(hzd), 32'd0);
    bus_rvl = 1'b1; bus_rdt = 32'h0000_0055;
    tick();
    bus_rvl = 1'b0;
    alu_vld = 1'b1; alu_rd = 5'd0; alu_dat = 32'h0000_0077;
    settle();
    check("x0_load_e_rd", 32'(e_rd), 32'd0);
    check("x0_load_busy", 32'(busy), 32'd0);
    tick();
    alu_vld = 1'b0;
    settle();
    check("x0_alu_e_rd", 32'(e_rd), 32'd0);

    // Response with empty FIFO is ignored
    bus_rvl = 1'b1; bus_err = 1'b1;
    tick();
    bus_rvl = 1'b0; bus_err = 1'b0;
    settle();
    check("spurious_e_rd", 32'(e_rd), 32'd0);
    check("spurious_ld_err", 32'(ld_err), 32'd0);

    // Reset mid-operation with two loads pending and a write in flight
    ld_vld = 1'b1; ld_rd = 5'd13; ld_f3 = 3'b010;
    tick();
    ld_rd = 5'd14;
    alu_vld = 1'b1; alu_rd = 5'd15; alu_dat = 32'h0000_00F0;
    tick();
    ld_vld = 1'b0; alu_vld = 1'b0;
    settle();
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_e_rd", 32'(e_rd), 32'd1);
    rst = 1'b0;
    settle();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_e_rd", 32'(e_rd), 32'd0);
    check("mid_rst_ld_rdy", 32'(ld_rdy), 32'd1);
    tick();
    rst = 1'b1;
    bus_rvl = 1'b1; bus_rdt = 32'h1234_5678;
    tick();
    bus_rvl = 1'b0;
    settle();
    check("post_rst_e_rd", 32'(e_rd), 32'd0);
    check("post_rst_ld_err", 32'(ld_err), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
